// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider:
//   DEFAULT_WIDTH : default operand/result width of seq_divider
//   state_e       : 3-bit controller state encoding used by div_control
// -----------------------------------------------------------------------------
package seq_divider_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      TEST  = 3'd2,
      WRITE = 3'd3,
      COUNT = 3'd4,
      DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/seq_divider_control.sv
// -----------------------------------------------------------------------------
// div_control
// Sequencing FSM and iteration counter for the restoring divider. It tells the
// datapath in seq_divider when to load operands, shift, commit a subtraction
// and latch the final (or divide-by-zero) result.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   go_i                : start request, only looked at in IDLE
//   divisorZero_i       : divisor input is zero (selects the shortcut path)
//   diffNeg_i           : trial subtraction went negative
//   load_o              : capture operands, clear working remainder
//   shift_o             : shift {rem,quo} left by one
//   write_o             : commit trial difference and set quotient LSB
//   increment_o         : advance the iteration counter
//   latchResult_o       : copy working registers to the result outputs
//   latchDivZero_o      : load the divide-by-zero result
//   done_o, busy_o      : status
// -----------------------------------------------------------------------------
module div_control
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic go_i,
   input  logic divisorZero_i,
   input  logic diffNeg_i,
   output logic load_o,
   output logic shift_o,
   output logic write_o,
   output logic increment_o,
   output logic latchResult_o,
   output logic latchDivZero_o,
   output logic done_o,
   output logic busy_o
);

   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;

   // State and iteration counter registers; reset drops any division in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state and datapath strobes. Each iteration is SHIFT, TEST, an
   // optional WRITE when the trial subtraction fits, then COUNT.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      load_o         = 1'b0;
      shift_o        = 1'b0;
      write_o        = 1'b0;
      increment_o    = 1'b0;
      latchResult_o  = 1'b0;
      latchDivZero_o = 1'b0;
      done_o         = 1'b0;
      busy_o         = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (go_i) begin
               if (divisorZero_i) begin
                  latchDivZero_o = 1'b1;
                  state_d        = DONE;
               end else begin
                  load_o  = 1'b1;
                  count_d = '0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            shift_o = 1'b1;
            state_d = TEST;
         end
         TEST: begin
            state_d = diffNeg_i ? COUNT : WRITE;
         end
         WRITE: begin
            write_o = 1'b1;
            state_d = COUNT;
         end
         COUNT: begin
            if (count_q == LAST_ITER) begin
               latchResult_o = 1'b1;
               state_d       = DONE;
            end else begin
               increment_o = 1'b1;
               count_d     = count_q + 1'b1;
               state_d     = SHIFT;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned sequential restoring divider, one quotient bit per iteration, MSB
// first. Division by zero short-circuits to quotient = all ones,
// remainder = dividend with div_by_zero set.
// Ports:
//   CLK, reset            : clock, asynchronous active-high reset
//   go                    : start request (ignored while busy)
//   dividend, divisor     : unsigned operands, captured when go is accepted
//   quotient, remainder   : registered results, updated only on DONE entry
//   busy                  : high whenever a division is in progress
//   done                  : one-cycle completion pulse
//   div_by_zero           : qualifies the latest result
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = seq_divider_pkg::DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);
   import seq_divider_pkg::*;

   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             divZero_q;

   logic [WIDTH+1:0] diff;
   logic             load, shiftEn, writeEn, increment;
   logic             latchResult, latchDivZero;

   // Single trial subtractor; one extra bit above rem gives the sign.
   assign diff = {1'b0, rem_q} - {2'b00, dvs_q};

   div_control #(.WIDTH(WIDTH)) u_control (
      .clk_i          (CLK),
      .rst_i          (reset),
      .go_i           (go),
      .divisorZero_i  (divisor == '0),
      .diffNeg_i      (diff[WIDTH+1]),
      .load_o         (load),
      .shift_o        (shiftEn),
      .write_o        (writeEn),
      .increment_o    (increment),
      .latchResult_o  (latchResult),
      .latchDivZero_o (latchDivZero),
      .done_o         (done),
      .busy_o         (busy)
   );

   // Working registers. rem needs WIDTH+1 bits because after the shift it can
   // reach just under twice the divisor before the subtraction restores it.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (shiftEn) begin
         {rem_q, quo_q} <= {rem_q[WIDTH-1:0], quo_q, 1'b0};
      end else if (writeEn) begin
         rem_q    <= diff[WIDTH:0];
         quo_q[0] <= 1'b1;
      end
   end

   // Result registers only move on DONE entry so they stay stable while busy.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         quotient_q  <= '0;
         remainder_q <= '0;
         divZero_q   <= 1'b0;
      end else if (latchResult) begin
         quotient_q  <= quo_q;
         remainder_q <= rem_q[WIDTH-1:0];
         divZero_q   <= 1'b0;
      end else if (latchDivZero) begin
         quotient_q  <= '1;
         remainder_q <= dividend;
         divZero_q   <= 1'b1;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = divZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed-vector bench for seq_divider (WIDTH = 32). Each scenario task
// drives its own stimulus and compares against hand-computed results.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int W = 32;
   localparam int TIMEOUT = 400;

   logic          CLK;
   logic          reset;
   logic          go;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   int compared;
   int mismatched;

   seq_divider #(.WIDTH(W)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .go          (go),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Present operands with go for one edge; returns #1 after the go edge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      dividend = a;
      divisor  = b;
      go       = 1'b1;
      @(posedge CLK);
      #1;
      go = 1'b0;
   endtask

   // Counts edges until done is seen, bounded by TIMEOUT.
   task automatic waitDone(output int cycles, output bit ok);
      cycles = 0;
      while (!done && cycles < TIMEOUT) begin
         @(posedge CLK);
         #1;
         cycles++;
      end
      ok = done;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      go       = 1'b0;
      dividend = '0;
      divisor  = '0;
      #2;
      compared++;
      if ({quotient, remainder, div_by_zero, busy, done} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got q=%h r=%h dz=%b busy=%b done=%b, want all 0",
                  quotient, remainder, div_by_zero, busy, done);
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   // Generic division check: result, flag, latency and single-cycle done.
   task automatic test_divide(input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] expQ,
                              input logic [W-1:0] expR, input logic expDz,
                              input int expLat);
      int cycles;
      bit ok;
      applyStimulus(a, b);
      waitDone(cycles, ok);
      compared++;
      if (!ok || cycles != expLat) begin
         mismatched++;
         $display("[TB] FAIL %s latency: got %0d (done=%b), want %0d", name, cycles, ok, expLat);
      end
      @(posedge CLK);
      #1;
      compared++;
      if (quotient !== expQ || remainder !== expR || div_by_zero !== expDz) begin
         mismatched++;
         $display("[TB] FAIL %s result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                  name, quotient, remainder, div_by_zero, expQ, expR, expDz);
      end
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s after_done: got done=%b busy=%b, want 0 0", name, done, busy);
      end
   endtask

   task automatic test_busy();
      int cycles;
      bit ok;
      applyStimulus(32'd100, 32'd7);
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL busy_after_go: got %b, want 1", busy);
      end
      waitDone(cycles, ok);
      compared++;
      if (!ok || cycles != 99 || quotient !== 32'd14 || remainder !== 32'd2) begin
         mismatched++;
         $display("[TB] FAIL busy_run: got lat=%0d q=%h r=%h, want 99 e 2", cycles, quotient, remainder);
      end
      @(posedge CLK);
      #1;
   endtask

   // go held high: second division starts in the IDLE cycle after DONE.
   task automatic test_back_to_back();
      int cycles;
      bit ok;
      dividend = 32'd20;
      divisor  = 32'd6;
      go       = 1'b1;
      @(posedge CLK);
      #1;
      waitDone(cycles, ok);
      compared++;
      if (!ok || cycles != 98 || quotient !== 32'd3 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b2b_first: got lat=%0d q=%h r=%h dz=%b, want 98 3 2 0",
                  cycles, quotient, remainder, div_by_zero);
      end
      dividend = 32'd7;
      divisor  = 32'd2;
      @(posedge CLK);
      #1;
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b2b_idle_gap: got busy=%b, want 0", busy);
      end
      @(posedge CLK);
      #1;
      go = 1'b0;
      waitDone(cycles, ok);
      compared++;
      if (!ok || cycles != 98 || quotient !== 32'd3 || remainder !== 32'd1) begin
         mismatched++;
         $display("[TB] FAIL b2b_second: got lat=%0d q=%h r=%h, want 98 3 1", cycles, quotient, remainder);
      end
      @(posedge CLK);
      #1;
   endtask

   // go and operand changes during a division must be ignored.
   task automatic test_ignore_go();
      int cycles;
      bit ok;
      applyStimulus(32'd100, 32'd7);
      repeat (10) @(posedge CLK);
      #1;
      applyStimulus(32'd50, 32'd5);
      dividend = 32'hDEAD;
      divisor  = 32'h0;
      compared++;
      if (quotient !== 32'd3 || remainder !== 32'd1) begin
         mismatched++;
         $display("[TB] FAIL ignore_hold: got q=%h r=%h, want 3 1", quotient, remainder);
      end
      waitDone(cycles, ok);
      compared++;
      if (!ok || cycles != 88 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL ignore_result: got lat=%0d q=%h r=%h dz=%b, want 88 e 2 0",
                  cycles, quotient, remainder, div_by_zero);
      end
      @(posedge CLK);
      #1;
   endtask

   // Reset mid-division clears outputs at once, no done, clean restart.
   task automatic test_reset_abort();
      bit sawDone;
      applyStimulus(32'd100, 32'd7);
      repeat (39) @(posedge CLK);
      #1;
      reset = 1'b1;
      #1;
      compared++;
      if ({quotient, remainder, div_by_zero, busy, done} !== '0) begin
         mismatched++;
         $display("[TB] FAIL abort_clear: got q=%h r=%h dz=%b busy=%b done=%b, want all 0",
                  quotient, remainder, div_by_zero, busy, done);
      end
      sawDone = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         if (done) sawDone = 1'b1;
      end
      @(negedge CLK);
      reset = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(posedge CLK);
         #1;
         if (done) sawDone = 1'b1;
      end
      compared++;
      if (sawDone !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_no_done: got sawDone=%b busy=%b, want 0 0", sawDone, busy);
      end
      test_divide("after_abort_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 98);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_busy();
      test_divide("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 99);
      test_divide("div_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 128);
      test_divide("div_wide_rem", 32'hFFFF_FFFE, 32'h8000_0001, 32'd1, 32'h7FFF_FFFD, 1'b0, 97);
      test_divide("div_by_zero", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0);
      test_back_to_back();
      test_ignore_go();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
